schedule_window: RTL and testbench

- Parametrised successor of the Qu schedule stage.
- Scans a sliding window of WINDOW consecutive reservation-station entries starting at rd_ptr. Each cycle it issues the oldest ready integer/control op to FIFO 1 and the oldest ready load/store op to FIFO 2.
- Adds FIFO backpressure, a partial window slide (the head advances past leading issued entries instead of waiting for the whole group), and a flush/redirect.
- Sits between the reservation station and the two execution-unit issue FIFOs.

---
 rtl/qu_common.sv | 28 ++
 rtl/sched_pick_oldest.sv | 30 +++
 rtl/schedule_window.sv | 126 ++++++++++++
 tb/tb_schedule_window.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qu_common.sv
// -----------------------------------------------------------------------------
// qu_common
//   Shared types for the Qu issue pipeline: reservation-station address and
//   cell layout, plus the schedule-window mask type and its default width.
//   No ports (package).
// -----------------------------------------------------------------------------
package qu_common;

  localparam int RS_ADDR_W = 4;  // reservation station depth = 2**RS_ADDR_W
  localparam int TAG_W     = 3;  // producer tag width, 0 means "operand ready"
  localparam int DATA_W    = 8;

  typedef logic [RS_ADDR_W-1:0] res_st_addr_t;

  // optype[0] = valid, optype[3] = load/store class.
  typedef struct packed {
    logic [3:0]        optype;
    logic [TAG_W-1:0]  dest;
    logic [TAG_W-1:0]  qj;
    logic [TAG_W-1:0]  qk;
    logic [DATA_W-1:0] vj;
    logic [DATA_W-1:0] vk;
  } res_st_cell_t;

  localparam int SCHED_WINDOW = 4;
  typedef logic [SCHED_WINDOW-1:0] sched_mask_t;

endpackage

// File: rtl/sched_pick_oldest.sv
// -----------------------------------------------------------------------------
// sched_pick_oldest
//   Fixed-priority encoder: bit 0 is the oldest request and wins.
//   Ports:
//     req   in  [N-1:0]  request vector
//     gnt   out [N-1:0]  one-hot grant (all zero when no request)
//     found out          at least one request present
// -----------------------------------------------------------------------------
module sched_pick_oldest #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic         found
);

  // NOTE: every output of an always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req[i] && !found) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/schedule_window.sv
// -----------------------------------------------------------------------------
// schedule_window
//   Scans WINDOW consecutive reservation-station entries starting at the head
//   pointer and issues, per cycle, the oldest ready integer/control op to
//   FIFO 1 and the oldest ready load/store op to FIFO 2. The head slides past
//   leading issued entries; entries issued out of order are remembered in a
//   per-slot mask until the head passes them.
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     en              stage enable (no issue, no state change when low)
//     flush/flush_ptr drop window state and move head to flush_ptr
//     res_st_rd_addr  per-slot read address (head + i)
//     res_st_rd_in    per-slot entry contents (combinational read)
//     fifo1/2_full    backpressure from the issue FIFOs
//     fifo_wr1/2_en   write strobes
//     op1/2_out       op written to each FIFO ('0 when not writing)
//     head_ptr        current head pointer
// -----------------------------------------------------------------------------
module schedule_window
  import qu_common::*;
#(
  parameter int WINDOW = SCHED_WINDOW,
  parameter int ADV_W  = $clog2(WINDOW + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         flush,
  input  res_st_addr_t flush_ptr,
  output res_st_addr_t res_st_rd_addr [WINDOW],
  input  res_st_cell_t res_st_rd_in   [WINDOW],
  input  logic         fifo1_full,
  input  logic         fifo2_full,
  output logic         fifo_wr1_en,
  output logic         fifo_wr2_en,
  output res_st_cell_t op1_out,
  output res_st_cell_t op2_out,
  output res_st_addr_t head_ptr
);

  res_st_addr_t      rd_ptr;
  logic [WINDOW-1:0] issued;

  logic [WINDOW-1:0] eligible, is_ldst, req1, req2, gnt1, gnt2;
  logic [WINDOW-1:0] issuing, done_mask, issued_nxt;
  logic              found1, found2;
  logic [ADV_W-1:0]  adv;

  // Number of consecutive set bits starting at bit 0.
  function automatic logic [ADV_W-1:0] lead_ones(input logic [WINDOW-1:0] m);
    logic [ADV_W-1:0] n;
    logic             run;
    n   = '0;
    run = 1'b1;
    for (int i = 0; i < WINDOW; i++) begin
      if (run && m[i]) n = n + ADV_W'(1);
      else             run = 1'b0;
    end
    return n;
  endfunction

  always_comb begin
    for (int i = 0; i < WINDOW; i++) begin
      res_st_rd_addr[i] = rd_ptr + res_st_addr_t'(i);
      eligible[i] = res_st_rd_in[i].optype[0] &&
                    (res_st_rd_in[i].qj == '0) &&
                    (res_st_rd_in[i].qk == '0) &&
                    !issued[i];
      is_ldst[i]  = res_st_rd_in[i].optype[3];
    end
  end

  assign req1 = eligible & ~is_ldst;
  assign req2 = eligible &  is_ldst;

  sched_pick_oldest #(.N(WINDOW)) u_pick_int (
    .req   (req1),
    .gnt   (gnt1),
    .found (found1)
  );

  sched_pick_oldest #(.N(WINDOW)) u_pick_ldst (
    .req   (req2),
    .gnt   (gnt2),
    .found (found2)
  );

  assign fifo_wr1_en = found1 && en && !fifo1_full && !flush && !rst;
  assign fifo_wr2_en = found2 && en && !fifo2_full && !flush && !rst;

  // A slot blocked by a full FIFO is not marked and is re-picked next cycle.
  assign issuing = (fifo_wr1_en ? gnt1 : '0) | (fifo_wr2_en ? gnt2 : '0);

  always_comb begin
    op1_out = '0;
    op2_out = '0;
    for (int i = 0; i < WINDOW; i++) begin
      if (fifo_wr1_en && gnt1[i]) op1_out = res_st_rd_in[i];
      if (fifo_wr2_en && gnt2[i]) op2_out = res_st_rd_in[i];
    end
  end

  // Slide the head past the leading run of issued slots; a shift by the full
  // width clears the mask entirely.
  assign done_mask  = issued | issuing;
  assign adv        = lead_ones(done_mask);
  assign issued_nxt = done_mask >> adv;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      issued <= '0;
    end else if (flush) begin
      rd_ptr <= flush_ptr;
      issued <= '0;
    end else if (en) begin
      rd_ptr <= rd_ptr + res_st_addr_t'(adv);
      issued <= issued_nxt;
    end
  end

  assign head_ptr = rd_ptr;

endmodule

// File: tb/tb_schedule_window.sv
// -----------------------------------------------------------------------------
// tb_schedule_window
//   Self-checking bench for schedule_window (WINDOW=4 main instance plus a
//   WINDOW=8 instance). A bench-side reservation-station array answers the
//   read addresses; expected FIFO writes are queued by each scenario and
//   popped by a negedge monitor.
// -----------------------------------------------------------------------------
module tb_schedule_window;
  import qu_common::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         en = 1'b0, en8 = 1'b0;
  logic         flush = 1'b0, flush8 = 1'b0;
  res_st_addr_t flush_ptr = '0, flush_ptr8 = '0;
  logic         fifo1_full = 1'b0, fifo2_full = 1'b0;

  res_st_addr_t rd_addr  [4];
  res_st_cell_t rd_in    [4];
  logic         fifo_wr1_en, fifo_wr2_en;
  res_st_cell_t op1_out, op2_out;
  res_st_addr_t head_ptr;

  res_st_addr_t rd_addr8 [8];
  res_st_cell_t rd_in8   [8];
  logic         wr1_8, wr2_8;
  res_st_cell_t op1_8, op2_8;
  res_st_addr_t head8;

  res_st_cell_t rs_mem [16];

  res_st_cell_t q1 [$];
  res_st_cell_t q2 [$];

  int n_checks = 0;
  int n_fail   = 0;

  always_comb begin
    for (int i = 0; i < 4; i++) rd_in[i]  = rs_mem[rd_addr[i]];
    for (int i = 0; i < 8; i++) rd_in8[i] = rs_mem[rd_addr8[i]];
  end

  schedule_window #(.WINDOW(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .flush          (flush),
    .flush_ptr      (flush_ptr),
    .res_st_rd_addr (rd_addr),
    .res_st_rd_in   (rd_in),
    .fifo1_full     (fifo1_full),
    .fifo2_full     (fifo2_full),
    .fifo_wr1_en    (fifo_wr1_en),
    .fifo_wr2_en    (fifo_wr2_en),
    .op1_out        (op1_out),
    .op2_out        (op2_out),
    .head_ptr       (head_ptr)
  );

  schedule_window #(.WINDOW(8)) dut8 (
    .clk            (clk),
    .rst            (rst),
    .en             (en8),
    .flush          (flush8),
    .flush_ptr      (flush_ptr8),
    .res_st_rd_addr (rd_addr8),
    .res_st_rd_in   (rd_in8),
    .fifo1_full     (1'b0),
    .fifo2_full     (1'b0),
    .fifo_wr1_en    (wr1_8),
    .fifo_wr2_en    (wr2_8),
    .op1_out        (op1_8),
    .op2_out        (op2_8),
    .head_ptr       (head8)
  );

  // Scoreboard monitor for the main instance.
  always @(negedge clk) begin
    res_st_cell_t e;
    n_checks++;
    if (fifo_wr1_en === 1'b1) begin
      if (q1.size() == 0) begin
        n_fail++;
        $display("FAIL sb_fifo1_unexpected: got op %h, expected no write", op1_out);
      end else begin
        e = q1.pop_front();
        if (op1_out !== e) begin
          n_fail++;
          $display("FAIL sb_fifo1_op: got %h, expected %h", op1_out, e);
        end
      end
    end else if (op1_out !== '0) begin
      n_fail++;
      $display("FAIL sb_fifo1_idle_zero: got %h, expected 0", op1_out);
    end
    n_checks++;
    if (fifo_wr2_en === 1'b1) begin
      if (q2.size() == 0) begin
        n_fail++;
        $display("FAIL sb_fifo2_unexpected: got op %h, expected no write", op2_out);
      end else begin
        e = q2.pop_front();
        if (op2_out !== e) begin
          n_fail++;
          $display("FAIL sb_fifo2_op: got %h, expected %h", op2_out, e);
        end
      end
    end else if (op2_out !== '0) begin
      n_fail++;
      $display("FAIL sb_fifo2_idle_zero: got %h, expected 0", op2_out);
    end
  end

  function automatic res_st_cell_t mk(input logic ldst, input logic [2:0] qj,
                                      input logic [7:0] tag);
    res_st_cell_t c;
    c.optype = ldst ? 4'b1001 : 4'b0001;
    c.dest   = tag[2:0];
    c.qj     = qj;
    c.qk     = '0;
    c.vj     = tag;
    c.vk     = ~tag;
    return c;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) rs_mem[i] = '0;
  endtask

  task automatic do_flush(input res_st_addr_t p);
    clear_mem();
    flush     = 1'b1;
    flush_ptr = p;
    step();
    flush = 1'b0;
  endtask

  task automatic drain_check(input string name);
    n_checks++;
    if (q1.size() != 0 || q2.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drained: got %0d/%0d pending writes, expected 0/0",
               name, q1.size(), q2.size());
      q1.delete();
      q2.delete();
    end
  endtask

  task automatic test_reset();
    clear_mem();
    rs_mem[0] = mk(1'b0, 3'd0, 8'h11);  // candidate present during reset
    rst = 1'b1;
    en  = 1'b1;
    step();
    step();
    n_checks++;
    if (fifo_wr1_en !== 1'b0 || fifo_wr2_en !== 1'b0 || op1_out !== '0) begin
      n_fail++;
      $display("FAIL reset_strobes: got wr1=%b wr2=%b op1=%h, expected 0 0 0",
               fifo_wr1_en, fifo_wr2_en, op1_out);
    end
    n_checks++;
    if (head_ptr !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_head: got %0d, expected 0", head_ptr);
    end
    n_checks++;
    if (head8 !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_head8: got %0d, expected 0", head8);
    end
    clear_mem();
    rst = 1'b0;
  endtask

  task automatic test_basic_issue();
    res_st_cell_t a, b, c, d;
    a = mk(1'b0, 3'd0, 8'hA0);
    b = mk(1'b1, 3'd0, 8'hB0);
    c = mk(1'b0, 3'd0, 8'hC0);
    d = mk(1'b1, 3'd0, 8'hD0);
    rs_mem[0] = a; rs_mem[1] = b; rs_mem[2] = c; rs_mem[3] = d;
    q1.push_back(a); q1.push_back(c);
    q2.push_back(b); q2.push_back(d);
    step();
    n_checks++;
    if (head_ptr !== 4'd2) begin
      n_fail++;
      $display("FAIL basic_head_c1: got %0d, expected 2", head_ptr);
    end
    step();
    n_checks++;
    if (head_ptr !== 4'd4) begin
      n_fail++;
      $display("FAIL basic_head_c2: got %0d, expected 4", head_ptr);
    end
    drain_check("basic");
  endtask

  task automatic test_out_of_order();
    res_st_cell_t s0, s1;
    do_flush(4'd0);
    s0 = mk(1'b0, 3'd5, 8'h30);
    s1 = mk(1'b0, 3'd0, 8'h31);
    rs_mem[0] = s0; rs_mem[1] = s1;
    q1.push_back(s1);
    step();
    n_checks++;
    if (head_ptr !== 4'd0) begin
      n_fail++;
      $display("FAIL ooo_head_hold: got %0d, expected 0", head_ptr);
    end
    step();  // slot 1 remembered as issued: must not reissue
    n_checks++;
    if (head_ptr !== 4'd0) begin
      n_fail++;
      $display("FAIL ooo_head_hold2: got %0d, expected 0", head_ptr);
    end
    s0.qj = '0;
    rs_mem[0] = s0;
    q1.push_back(s0);
    step();
    n_checks++;
    if (head_ptr !== 4'd2) begin
      n_fail++;
      $display("FAIL ooo_head_slide: got %0d, expected 2", head_ptr);
    end
    drain_check("ooo");
  endtask

  task automatic test_backpressure();
    res_st_cell_t g, h;
    do_flush(4'd0);
    g = mk(1'b0, 3'd0, 8'h60);
    h = mk(1'b1, 3'd0, 8'h61);
    rs_mem[0] = g; rs_mem[1] = h;
    fifo1_full = 1'b1;
    q2.push_back(h);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (fifo_wr1_en !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_wr1_blocked c%0d: got %b, expected 0", c, fifo_wr1_en);
      end
      step();
      n_checks++;
      if (head_ptr !== 4'd0) begin
        n_fail++;
        $display("FAIL bp_head c%0d: got %0d, expected 0", c, head_ptr);
      end
    end
    fifo1_full = 1'b0;
    q1.push_back(g);
    step();
    n_checks++;
    if (head_ptr !== 4'd2) begin
      n_fail++;
      $display("FAIL bp_release_head: got %0d, expected 2", head_ptr);
    end
    drain_check("bp");
  endtask

  task automatic test_wrap();
    res_st_cell_t w [4];
    logic [3:0] exp_addr [4];
    exp_addr[0] = 4'd14; exp_addr[1] = 4'd15; exp_addr[2] = 4'd0; exp_addr[3] = 4'd1;
    do_flush(4'd14);
    #1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (rd_addr[i] !== exp_addr[i]) begin
        n_fail++;
        $display("FAIL wrap_addr[%0d]: got %0d, expected %0d", i, rd_addr[i], exp_addr[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      w[i] = mk(i[0], 3'd0, 8'(8'h70 + i));
      rs_mem[exp_addr[i]] = w[i];
    end
    q1.push_back(w[0]); q1.push_back(w[2]);
    q2.push_back(w[1]); q2.push_back(w[3]);
    step();
    n_checks++;
    if (head_ptr !== 4'd0) begin
      n_fail++;
      $display("FAIL wrap_head_c1: got %0d, expected 0", head_ptr);
    end
    step();
    n_checks++;
    if (head_ptr !== 4'd2) begin
      n_fail++;
      $display("FAIL wrap_head_c2: got %0d, expected 2", head_ptr);
    end
    drain_check("wrap");
  endtask

  task automatic test_flush();
    res_st_cell_t n;
    rs_mem[2] = mk(1'b0, 3'd0, 8'h90);
    rs_mem[3] = mk(1'b1, 3'd0, 8'h91);
    flush     = 1'b1;
    flush_ptr = 4'd9;
    #1;
    n_checks++;
    if (fifo_wr1_en !== 1'b0 || fifo_wr2_en !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_strobes: got wr1=%b wr2=%b, expected 0 0", fifo_wr1_en, fifo_wr2_en);
    end
    step();
    flush = 1'b0;
    n_checks++;
    if (head_ptr !== 4'd9) begin
      n_fail++;
      $display("FAIL flush_head: got %0d, expected 9", head_ptr);
    end
    n = mk(1'b0, 3'd0, 8'h99);
    rs_mem[9] = n;
    q1.push_back(n);
    step();
    n_checks++;
    if (head_ptr !== 4'd10) begin
      n_fail++;
      $display("FAIL flush_then_issue_head: got %0d, expected 10", head_ptr);
    end
    rs_mem[10] = mk(1'b0, 3'd0, 8'h9A);
    rst       = 1'b1;
    flush     = 1'b1;
    flush_ptr = 4'd5;
    #1;
    n_checks++;
    if (fifo_wr1_en !== 1'b0 || fifo_wr2_en !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_flush_strobes: got wr1=%b wr2=%b, expected 0 0", fifo_wr1_en, fifo_wr2_en);
    end
    step();
    rst   = 1'b0;
    flush = 1'b0;
    clear_mem();
    n_checks++;
    if (head_ptr !== 4'd0) begin
      n_fail++;
      $display("FAIL rst_over_flush_head: got %0d, expected 0", head_ptr);
    end
    drain_check("flush");
  endtask

  task automatic test_enable();
    res_st_cell_t p;
    p = mk(1'b0, 3'd0, 8'h50);
    rs_mem[0] = p;
    en = 1'b0;
    #1;
    n_checks++;
    if (fifo_wr1_en !== 1'b0) begin
      n_fail++;
      $display("FAIL en_low_strobe: got %b, expected 0", fifo_wr1_en);
    end
    step();
    step();
    n_checks++;
    if (head_ptr !== 4'd0) begin
      n_fail++;
      $display("FAIL en_low_head: got %0d, expected 0", head_ptr);
    end
    en = 1'b1;
    q1.push_back(p);
    step();
    n_checks++;
    if (head_ptr !== 4'd1) begin
      n_fail++;
      $display("FAIL en_high_head: got %0d, expected 1", head_ptr);
    end
    drain_check("enable");
  endtask

  task automatic test_window8();
    res_st_cell_t k;
    en = 1'b0;
    clear_mem();
    k = mk(1'b0, 3'd0, 8'hE7);
    rs_mem[7] = k;
    en8 = 1'b1;
    #1;
    n_checks++;
    if (wr1_8 !== 1'b1 || op1_8 !== k || wr2_8 !== 1'b0) begin
      n_fail++;
      $display("FAIL w8_issue: got wr1=%b op1=%h wr2=%b, expected 1 %h 0", wr1_8, op1_8, wr2_8, k);
    end
    step();
    n_checks++;
    if (head8 !== 4'd0) begin
      n_fail++;
      $display("FAIL w8_head: got %0d, expected 0", head8);
    end
    n_checks++;
    if (wr1_8 !== 1'b0) begin
      n_fail++;
      $display("FAIL w8_no_reissue: got %b, expected 0", wr1_8);
    end
    step();
    n_checks++;
    if (head8 !== 4'd0) begin
      n_fail++;
      $display("FAIL w8_head_hold: got %0d, expected 0", head8);
    end
    en8 = 1'b0;
    clear_mem();
  endtask

  initial begin
    clear_mem();
    test_reset();
    test_basic_issue();
    test_out_of_order();
    test_backpressure();
    test_wrap();
    test_flush();
    test_enable();
    test_window8();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
